// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads a program received as a UART byte stream into the
// instruction memory and keeps the CPU parked on NOPs until the load is done.
// Stream format: 16-bit big-endian word count N, then N big-endian 32-bit words.
// Words go to addresses 0..N-1; the rest of the memory is zero-filled.
module imem_boot_loader #(
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_req,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       ir_in,
    output logic [31:0]       ir_out,
    output logic              cpu_hold,
    output logic              busy,
    output logic              load_done,
    output logic              load_err
);

    // One extra counter bit so a full-depth load (N == DEPTH) does not wrap.
    localparam int CNT_W = ADDR_W + 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEPTH - 1);
    localparam logic [16:0]      HDR_MAX   = 17'(DEPTH);
    localparam logic [TO_W-1:0]  TO_ONE    = TO_W'(1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        DATA,
        CLEAR,
        DONE,
        ERR
    } state_t;

    state_t state;
    state_t state_next;

    logic [7:0]       n_hi;       // header high byte, held until the low byte arrives
    logic [CNT_W-1:0] n_words;    // word count N of the current load
    logic [CNT_W-1:0] word_cnt;   // next word address to write
    logic [1:0]       byte_cnt;   // bytes of the current word already accepted
    logic [23:0]      shreg;      // first three bytes of the word being assembled
    logic [TO_W-1:0]  to_cnt;     // idle cycles since the last accepted byte

    logic        accept;
    logic        start;
    logic        to_expire;
    logic        word_last;
    logic [15:0] hdr_n;

    assign accept    = rx_valid && rx_ready;
    assign start     = load_req && (state == IDLE || state == DONE || state == ERR);
    assign hdr_n     = {n_hi, rx_data};
    // Another idle edge would bring the counter to TIMEOUT.
    assign to_expire = (to_cnt == TO_LAST);
    // The byte being accepted completes the last word of the program.
    assign word_last = (byte_cnt == 2'd3) && ((word_cnt + CNT_ONE) == n_words);

    // Fetch path: NOP while the CPU is held, memory contents otherwise.
    assign ir_out = cpu_hold ? 32'h0 : ir_in;

    // State register; rst returns to IDLE at once, releasing the CPU.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential logic uses non-blocking assignments so every flop samples pre-edge values.
            state <= state_next;
        end
    end

    // Next-state logic and the outputs decoded from the current state.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_next = state;
        rx_ready   = 1'b0;
        busy       = 1'b0;
        cpu_hold   = 1'b0;
        load_err   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (load_req) state_next = HDR0;
            end
            HDR0: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                cpu_hold = 1'b1;
                if (rx_valid)       state_next = HDR1;
                else if (to_expire) state_next = ERR;
            end
            HDR1: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                cpu_hold = 1'b1;
                if (rx_valid) begin
                    if ({1'b0, hdr_n} > HDR_MAX) state_next = ERR;
                    else if (hdr_n == 16'd0)     state_next = CLEAR;
                    else                         state_next = DATA;
                end else if (to_expire) begin
                    state_next = ERR;
                end
            end
            DATA: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                cpu_hold = 1'b1;
                if (rx_valid) begin
                    if (word_last) state_next = (n_words == CNT_DEPTH) ? DONE : CLEAR;
                end else if (to_expire) begin
                    state_next = ERR;
                end
            end
            CLEAR: begin
                busy     = 1'b1;
                cpu_hold = 1'b1;
                if (word_cnt == CNT_LAST) state_next = DONE;
            end
            ERR: begin
                cpu_hold = 1'b1;
                load_err = 1'b1;
                if (load_req) state_next = HDR0;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: header capture, word assembly, memory write port, timeout counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_hi      <= '0;
            n_words   <= '0;
            word_cnt  <= '0;
            byte_cnt  <= '0;
            shreg     <= '0;
            to_cnt    <= '0;
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
            load_done <= 1'b0;
        end else begin
            mem_we    <= 1'b0;
            load_done <= (state != DONE) && (state_next == DONE);
            if (start) begin
                word_cnt <= '0;
                byte_cnt <= '0;
                to_cnt   <= '0;
            end else begin
                // Timeout only runs while bytes are expected.
                if (rx_ready) to_cnt <= accept ? '0 : to_cnt + TO_ONE;
                case (state)
                    HDR0: begin
                        if (accept) n_hi <= rx_data;
                    end
                    HDR1: begin
                        if (accept) begin
                            n_words  <= hdr_n[CNT_W-1:0];
                            word_cnt <= '0;
                        end
                    end
                    DATA: begin
                        if (accept) begin
                            shreg    <= {shreg[15:0], rx_data};
                            byte_cnt <= byte_cnt + 2'd1;
                            // Fourth byte: write the word straight from the shifter.
                            if (byte_cnt == 2'd3) begin
                                mem_we    <= 1'b1;
                                mem_waddr <= word_cnt[ADDR_W-1:0];
                                mem_wdata <= {shreg, rx_data};
                                word_cnt  <= word_cnt + CNT_ONE;
                            end
                        end
                    end
                    CLEAR: begin
                        mem_we    <= 1'b1;
                        mem_waddr <= word_cnt[ADDR_W-1:0];
                        mem_wdata <= 32'h0;
                        word_cnt  <= word_cnt + CNT_ONE;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
